// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO between the UART receive path and the transmitter.
// It drains one byte at a time over a tx_sig/tx_done_sig handshake.
module uart_tx_fifo #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [7:0]        wr_data,
  input  logic              tx_done_sig,
  output logic              tx_sig,
  output logic [7:0]        tx_data,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   count,
  output logic              overflow
);
  typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;
  state_t            r_state;
  logic [7:0]        r_mem [DEPTH];
  logic [ADDR_W-1:0] r_wr_ptr, r_rd_ptr;
  logic [ADDR_W:0]   r_count;
  logic              r_ready, r_tx_sig, r_overflow;
  logic [7:0]        r_tx_data;
  logic              w_full, w_empty, w_pop, w_wr;
  assign w_full  = r_count == (ADDR_W+1)'(DEPTH);
  assign w_empty = r_count == '0;
  // r_ready lags empty by a cycle, so a fresh byte launches two edges after its write
  assign w_pop   = (r_state == IDLE) && r_ready && !w_empty;
  assign w_wr    = wr_en && (!w_full || w_pop);
  always_ff @(posedge clk)
    if (w_wr) r_mem[r_wr_ptr] <= wr_data;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_ready    <= 1'b0;
      r_overflow <= 1'b0;
      r_tx_sig   <= 1'b0;
      r_tx_data  <= 8'h00;
      r_state    <= IDLE;
    end else begin
      r_ready <= !w_empty;
      r_count <= r_count + (ADDR_W+1)'(w_wr) - (ADDR_W+1)'(w_pop);
      if (w_wr) r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
      if (wr_en && !w_wr) r_overflow <= 1'b1;
      case (r_state)
        IDLE: if (w_pop) begin
          r_tx_data <= r_mem[r_rd_ptr];
          r_tx_sig  <= 1'b1;
          r_rd_ptr  <= r_rd_ptr + ADDR_W'(1);
          r_state   <= SEND;
        end
        SEND: if (tx_done_sig) begin
          r_tx_sig <= 1'b0;
          r_state  <= GAP;
        end
        GAP:     r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end
  assign tx_sig   = r_tx_sig;
  assign tx_data  = r_tx_data;
  assign full     = w_full;
  assign empty    = w_empty;
  assign count    = r_count;
  assign overflow = r_overflow;
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: randomized and directed checks of uart_tx_fifo against a queue-based model.
module tb_uart_tx_fifo;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       wr_en = 1'b0, tx_done_sig = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       tx_sig, full, empty, overflow;
  logic [7:0] tx_data;
  logic [4:0] count;
  int         checks = 0, failures = 0;
  logic [7:0] m_q [$];
  int         m_state = 0;
  logic       m_ready = 0, m_sig = 0, m_ovf = 0;
  logic [7:0] m_tx = 8'h00;
  logic [7:0] got [$];
  logic       prev_sig = 0;
  int         low_run = 0, last_gap = 0, rises = 0;

  uart_tx_fifo #(.DEPTH(16), .ADDR_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_data(wr_data),
    .tx_done_sig(tx_done_sig), .tx_sig(tx_sig), .tx_data(tx_data),
    .full(full), .empty(empty), .count(count), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_state = 0; m_ready = 0; m_sig = 0; m_ovf = 0; m_tx = 8'h00;
    prev_sig = 0; low_run = 0;
  endtask

  task automatic model_edge(input logic wr, input logic [7:0] d, input logic done);
    int  sz;
    logic pop, ok;
    sz  = m_q.size();
    pop = (m_state == 0) && m_ready && (sz != 0);
    ok  = wr && (sz < 16 || pop);
    if (pop) begin
      m_tx = m_q.pop_front(); m_sig = 1; m_state = 1;
    end else if (m_state == 1 && done) begin
      m_sig = 0; m_state = 2;
    end else if (m_state == 2) m_state = 0;
    if (ok) m_q.push_back(d);
    else if (wr) m_ovf = 1;
    m_ready = (sz != 0);
  endtask

  task automatic step(input logic wr, input logic [7:0] d, input logic done);
    wr_en = wr; wr_data = d; tx_done_sig = done;
    @(posedge clk);
    model_edge(wr, d, done);
    #1;
    wr_en = 0; tx_done_sig = 0;
    check("tx_sig", tx_sig, m_sig);
    check("tx_data", tx_data, m_tx);
    check("count", count, m_q.size());
    check("empty", empty, m_q.size() == 0);
    check("full", full, m_q.size() == 16);
    check("overflow", overflow, m_ovf);
    if (tx_sig && !prev_sig) begin
      got.push_back(tx_data); rises++; last_gap = low_run;
    end
    low_run = tx_sig ? 0 : low_run + 1;
    prev_sig = tx_sig;
  endtask

  task automatic do_reset();
    rst_n = 0;
    #2;
    check("rst_tx_sig", tx_sig, 0);
    check("rst_count", count, 0);
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_overflow", overflow, 0);
    check("rst_tx_data", tx_data, 8'h00);
    model_reset();
    @(posedge clk);
    #1 rst_n = 1;
    got.delete(); rises = 0;
  endtask

  initial begin
    int n;
    #3;
    check("init_tx_sig", tx_sig, 0);
    check("init_empty", empty, 1);
    @(posedge clk);
    #1 rst_n = 1;
    // single byte latency
    step(1, 8'h5A, 0);
    check("lat_k", tx_sig, 0);
    step(0, 0, 0);
    check("lat_k1", tx_sig, 0);
    step(0, 0, 0);
    check("lat_k2", tx_sig, 1);
    check("lat_data", tx_data, 8'h5A);
    repeat (17) step(0, 0, 0);
    step(0, 0, 1);
    check("single_done", tx_sig, 0);
    check("single_empty", empty, 1);
    // burst order and inter-byte gap
    do_reset();
    for (int i = 1; i <= 5; i++) step(1, 8'(i), 0);
    for (int c = 0; c < 120; c++) begin
      n = got.size();
      step(0, 0, (c % 20) == 19);
      if (got.size() > n && got.size() > 1) check("burst_gap", last_gap, 2);
    end
    check("burst_n", got.size(), 5);
    for (int i = 0; i < 5 && i < got.size(); i++) check("burst_data", got[i], i + 1);
    // overflow
    do_reset();
    for (int i = 0; i < 17; i++) step(1, 8'h10 + 8'(i), 0);
    check("ovf_full", full, 1);
    check("ovf_pre", overflow, 0);
    step(1, 8'hEE, 0);
    check("ovf_flag", overflow, 1);
    check("ovf_count", count, 16);
    for (int c = 0; c < 200; c++) step(0, 0, (c % 4) == 3);
    check("ovf_drained", empty, 1);
    check("ovf_n", got.size(), 17);
    for (int i = 0; i < got.size(); i++) check("ovf_no_drop", got[i] == 8'hEE, 0);
    // simultaneous write and pop at full
    do_reset();
    for (int i = 0; i < 17; i++) step(1, 8'h20 + 8'(i), 0);
    step(0, 0, 1);
    step(0, 0, 0);
    step(1, 8'hAB, 0);
    check("wp_count", count, 16);
    check("wp_ovf", overflow, 0);
    check("wp_sig", tx_sig, 1);
    for (int c = 0; c < 200; c++) step(0, 0, (c % 4) == 3);
    check("wp_last", got.size() > 0 ? got[got.size()-1] : 8'h00, 8'hAB);
    // pointer wrap with 40 bytes
    do_reset();
    n = 0;
    for (int c = 0; c < 2000 && !(n == 40 && m_q.size() == 0 && m_state == 0); c++) begin
      if (n < 40 && m_q.size() < 16 && (c % 2) == 0) begin
        step(1, 8'(n), (c % 3) == 0);
        n++;
      end else step(0, 0, (c % 3) == 0);
    end
    check("wrap_n", got.size(), 40);
    for (int i = 0; i < got.size(); i++) check("wrap_data", got[i], i);
    check("wrap_count", count, 0);
    // random traffic
    do_reset();
    for (int c = 0; c < 3000; c++)
      step($urandom_range(0, 9) < 4, 8'($urandom), $urandom_range(0, 3) == 0);
    // reset mid-send
    do_reset();
    for (int i = 0; i < 6; i++) step(1, 8'h40 + 8'(i), 0);
    check("mid_sig", tx_sig, 1);
    check("mid_count", count, 5);
    do_reset();
    step(1, 8'hC3, 0);
    step(0, 0, 0);
    step(0, 0, 0);
    check("post_sig", tx_sig, 1);
    check("post_data", tx_data, 8'hC3);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
